// File: rtl/audio_wave_pulsewidth_pkg.sv
// Shared constants and waveform mode encoding for the pulsewidth level generator.
// These take the place of the audio_values.vh defines: widths, the muted level and the wave shape codes.
package audio_wave_pulsewidth_pkg;
   localparam int PERWIDTH_DEF = 20;
   localparam int BITRES_DEF   = 4;
   localparam int PWM_MUTED    = 0;

   typedef enum logic [1:0] {
      WAVE_SAW_UP = 2'd0,
      WAVE_SAW_DN = 2'd1,
      WAVE_TRI    = 2'd2,
      WAVE_SQR    = 2'd3
   } wave_mode_e;

   // Triangle walks T over 2*RES levels per cycle; all other shapes over RES.
   function automatic int wave_step(input wave_mode_e m, input int res);
      return (m == WAVE_TRI) ? 2 * res : res;
   endfunction
endpackage

// File: rtl/audio_wave_pulsewidth_if.sv
// Control inputs and level outputs of the pulsewidth generator.
interface audio_wave_pulsewidth_if
   import audio_wave_pulsewidth_pkg::*;
#(
   parameter int PERWIDTH = PERWIDTH_DEF,
   parameter int BITRES   = BITRES_DEF
);
   logic                mute;
   logic [PERWIDTH-1:0] period;
   wave_mode_e          mode;
   logic [BITRES-1:0]   duty;
   logic [BITRES-1:0]   pulsewidth;
   logic                wrap;

   modport master (output mute, period, mode, duty, input pulsewidth, wrap);
   modport slave  (input mute, period, mode, duty, output pulsewidth, wrap);
endinterface

// File: rtl/audio_frac_stepper.sv
// Phase counter plus error accumulator: t_o = floor(count*step/(p+1)), built up one step per clock.
module audio_frac_stepper #(
   parameter int PERWIDTH = 20,
   parameter int BITRES   = 4
) (
   input  logic                clk,
   input  logic                clear_i,
   input  logic [PERWIDTH-1:0] p_i,
   input  logic [BITRES+1:0]   step_i,
   output logic [BITRES:0]     t_o,
   output logic                phase_start_o
);
   logic [PERWIDTH-1:0] count_q, count_d;
   logic [PERWIDTH:0]   e_q, e_d;
   logic [BITRES:0]     t_q, t_d;
   logic [PERWIDTH+1:0] e_sum, p_plus1;

   assign e_sum   = {1'b0, e_q} + (PERWIDTH+2)'(step_i);
   assign p_plus1 = {2'b00, p_i} + (PERWIDTH+2)'(1);

   // p_i >= step_i - 1 is guaranteed by the clamp upstream, so at most one carry per clock.
   always_comb begin
      count_d = count_q + 1'b1;
      e_d     = (PERWIDTH+1)'(e_sum);
      t_d     = t_q;
      if (count_q == p_i) begin
         count_d = '0;
         e_d     = '0;
         t_d     = '0;
      end else if (e_sum >= p_plus1) begin
         e_d = (PERWIDTH+1)'(e_sum - p_plus1);
         t_d = t_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (clear_i) begin
         count_q <= '0;
         e_q     <= '0;
         t_q     <= '0;
      end else begin
         count_q <= count_d;
         e_q     <= e_d;
         t_q     <= t_d;
      end
   end

   assign t_o           = t_q;
   assign phase_start_o = (count_q == '0);
endmodule

// File: rtl/audio_wave_pulsewidth.sv
// Multi-shape pulsewidth level generator: period clamp, phase-start shadow registers,
// shaping and the registered level/wrap outputs around a fractional stepper.
module audio_wave_pulsewidth
   import audio_wave_pulsewidth_pkg::*;
#(
   parameter int PERWIDTH = PERWIDTH_DEF,
   parameter int BITRES   = BITRES_DEF
) (
   input logic                     clk,
   input logic                     resetn,
   audio_wave_pulsewidth_if.slave  bus
);
   localparam int                  RES   = 2 ** BITRES;
   localparam logic [PERWIDTH-1:0] P_MIN = PERWIDTH'(2 * RES - 1);

   logic                active, phase_start, start;
   logic [PERWIDTH-1:0] period_s_q, period_eff, p_eff;
   wave_mode_e          mode_s_q, mode_eff;
   logic [BITRES-1:0]   duty_s_q, duty_eff, level_d, pulsewidth_q;
   logic                wrap_q;
   logic [BITRES:0]     t;
   logic [BITRES+1:0]   step;

   assign active = resetn & ~bus.mute;
   assign start  = active & phase_start;

   // On the phase-start cycle the ports drive everything directly; afterwards the shadows hold.
   assign period_eff = start ? bus.period : period_s_q;
   assign mode_eff   = start ? bus.mode   : mode_s_q;
   assign duty_eff   = start ? bus.duty   : duty_s_q;
   assign p_eff      = (period_eff < P_MIN) ? P_MIN : period_eff;
   assign step       = (BITRES+2)'(wave_step(mode_eff, RES));

   audio_frac_stepper #(.PERWIDTH(PERWIDTH), .BITRES(BITRES)) u_stepper (
      .clk           (clk),
      .clear_i       (~active),
      .p_i           (p_eff),
      .step_i        (step),
      .t_o           (t),
      .phase_start_o (phase_start)
   );

   always_comb begin
      level_d = '0;
      case (mode_eff)
         WAVE_SAW_UP: level_d = t[BITRES-1:0];
         WAVE_SAW_DN: level_d = BITRES'(RES - 1) - t[BITRES-1:0];
         // Second half of the triangle: 2*RES-1-T is the bitwise complement of T's low bits.
         WAVE_TRI:    level_d = t[BITRES] ? ~t[BITRES-1:0] : t[BITRES-1:0];
         WAVE_SQR:    level_d = (t < {1'b0, duty_eff}) ? {BITRES{1'b1}} : '0;
         default:     level_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!active) begin
         period_s_q   <= P_MIN;
         mode_s_q     <= WAVE_SAW_UP;
         duty_s_q     <= '0;
         pulsewidth_q <= BITRES'(PWM_MUTED);
         wrap_q       <= 1'b0;
      end else begin
         if (start) begin
            period_s_q <= bus.period;
            mode_s_q   <= bus.mode;
            duty_s_q   <= bus.duty;
         end
         pulsewidth_q <= level_d;
         wrap_q       <= start;
      end
   end

   assign bus.pulsewidth = pulsewidth_q;
   assign bus.wrap       = wrap_q;
endmodule

// File: doc/audio_wave_pulsewidth.md
# audio_wave_pulsewidth

Parametrised multi-mode successor to the single sawtooth pulsewidth generator. It produces a `BITRES`-bit pulsewidth level stream for the PWM audio output stage. Supported shapes are sawtooth up, sawtooth down, triangle and variable-duty square, all with a programmable period. Levels come from an incremental fractional stepper instead of `2^BITRES` parallel multiply-compares. This makes wide `BITRES` and `PERWIDTH` affordable.

## Interface
- `PERWIDTH`, default `` `PERWIDTH `` (20): width of the period and count.
- `BITRES`, default `` `BITRES `` (4): level resolution. `RES = 2**BITRES`.
- `clk` input 1: system clock (100 MHz).
- `resetn` input 1: reset. Synchronous, active-low.
- `mute` input 1: synchronous, active-high. Same effect as reset.
- `period` input `PERWIDTH`: one waveform cycle lasts `period+1` clocks.
- `mode` input 2: `WAVE_SAW_UP`=0, `WAVE_SAW_DN`=1, `WAVE_TRI`=2, `WAVE_SQR`=3.
- `duty` input `BITRES`: square high-time, in units of `1/RES` of the cycle.
- `pulsewidth` output `BITRES`: registered level.
- `wrap` output 1: one-cycle pulse on the phase-start cycle.

## Operation
- **Effective period.** `P = max(period_s, 2*RES-1)`. Smaller `period` values are clamped, so at most one level step occurs per clock.
- **Phase counter.** `count` runs 0..P, then returns to 0. The cycle where `count==0` while active is the phase-start cycle.
- **Phase-start sampling.** On the phase-start cycle:
  - `period_s`, `mode_s` and `duty_s` load from the ports.
  - `wrap` is 1.
  - Changes to the inputs at any other time take effect only at the next phase start. No mid-cycle glitches.
- **Fractional stepper.** Computes `T = floor(count*STEP/(P+1))` incrementally.
  - `STEP = 2*RES` in triangle mode, `RES` otherwise.
  - Each increment: `e' = e + STEP`. If `e' >= P+1`, then `e <= e' - (P+1)` and `T <= T+1`; otherwise `e <= e'`.
  - `e`, `T` and `count` clear at phase start.
  - `e` is `PERWIDTH+1` bits. `T` is `BITRES+1` bits.
- **Shaping**, in the registered output stage:
  - `WAVE_SAW_UP`: `T`.
  - `WAVE_SAW_DN`: `RES-1-T`.
  - `WAVE_TRI`: `T` if `T<RES`, else `2*RES-1-T`.
  - `WAVE_SQR`: `RES-1` if `T<duty`, else 0. `duty=0` gives constant 0.
  - On the phase-start cycle, shaping uses the newly sampled `mode`/`duty`.
- **Reset or mute** (mute checked as `~resetn | mute`, priority over everything):
  - `count`, `e`, `T` clear to 0; `wrap` = 0; `pulsewidth` = `` `PWM_MUTED ``.
  - `period_s` = `2*RES-1`, `mode_s` = `WAVE_SAW_UP`, `duty_s` = 0.
  - The first active cycle after release is a phase start.

## Timing
- Level latency is 1 clock: `pulsewidth` in cycle n+1 reflects `count` in cycle n.
- `wrap` is registered and aligned with the first `pulsewidth` of the new cycle.
- Cycle length is exactly `P+1` clocks with no drift. Levels over one cycle are monotone per shape.
- **Boundaries:**
  - `count==P` is always followed by phase start.
  - A period changed to a value below the current `count` has no effect until phase start.
  - Mute asserted mid-cycle forces `PWM_MUTED` on the next clock.
  - `resetn` low together with `mute` gives reset behaviour; the two are identical.

## Structure
- `audio_values.vh` holds:
  - `PERWIDTH` and `BITRES` defaults, and `PWM_MUTED`;
  - new `WAVE_SAW_UP`, `WAVE_SAW_DN`, `WAVE_TRI` and `WAVE_SQR` defines.
- One sub-module, `audio_frac_stepper`. It contains the phase counter and the error accumulator. Inputs: `P`, `STEP`, clear. Outputs: `T`, phase start.
- The top level does clamp, shadow registers, shaping, and the `wrap`/output registers.

## Test plan
- **Sawtooth up.** `BITRES=4`, `period=31`, `WAVE_SAW_UP` -> `pulsewidth` 0,0,1,1,…,15,15 repeating every 32 clocks; `wrap` every 32nd clock.
- **Triangle.** `period=31`, `WAVE_TRI` -> 0,1,…,15,15,14,…,0 per 32 clocks. With `period=63`, each level is held 2 clocks.
- **Square.** `WAVE_SQR`, `duty=4`, `period=31` -> 15 for 8 clocks, then 0 for 24. With `duty=0`, constant 0.
- **Period clamp.** `period=5` -> behaves identically to `period=31`, with a 32-clock cycle.
- **Mid-cycle change.** Switch `mode` and `period` mid-cycle -> the old shape completes, and the new one starts exactly at the next `wrap`.
- **Mute and reset.** Assert `mute` at `count=10` -> `PWM_MUTED` next clock. On release, `wrap`=1 and a fresh cycle from level 0. The same for `resetn` low.
